// File: rtl/prefetcher_tb_pkg.sv
// Shared definitions for the strided AXI read initiator.
// Contents: run-state enum and the bit positions of the errorCode flags.
package prefetcher_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  localparam int ERR_ID_BIT     = 0;  // returned ID differs from the run ID
  localparam int ERR_LAST_BIT   = 1;  // r_last disagrees with the burst position
  localparam int ERR_ORPHAN_BIT = 2;  // beat arrived with no burst outstanding

endpackage

// File: rtl/axi_rd_beat_checker.sv
// Read-data side bookkeeping for axi_stride_rd_master.
// Tracks the beat position inside the current burst, the number of
// outstanding bursts and the sticky protocol error flags.
// Ports:
//   clk, resetN          clock, async active-low reset
//   clear                accepted start: drop flags and burst position
//   ar_hs, r_hs, r_last  handshake strobes from the AR/R channels
//   r_id, id, len        returned ID, run ID and run burst length
//   outstanding(_next)   current / next-cycle outstanding burst count
//   error_code           sticky flags {orphan, last, id}
module axi_rd_beat_checker
  import prefetcher_tb_pkg::*;
#(
  parameter int BURST_LEN_WIDTH     = 8,
  parameter int TID_WIDTH           = 8,
  parameter int LOG_MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         clear,
  input  logic                         ar_hs,
  input  logic                         r_hs,
  input  logic                         r_last,
  input  logic [TID_WIDTH-1:0]         r_id,
  input  logic [TID_WIDTH-1:0]         id,
  input  logic [BURST_LEN_WIDTH-1:0]   len,
  output logic [LOG_MAX_OUTSTANDING:0] outstanding,
  output logic [LOG_MAX_OUTSTANDING:0] outstanding_next,
  output logic [2:0]                   error_code
);

  localparam int OW = LOG_MAX_OUTSTANDING + 1;

  logic [BURST_LEN_WIDTH-1:0] beat_idx;
  logic                       have_outstanding;
  logic                       retire;

  assign have_outstanding = (outstanding != '0);
  // A last beat only retires a burst if one is actually in flight.
  assign retire = r_hs && r_last && have_outstanding;

  always_comb begin
    outstanding_next = outstanding;
    if (ar_hs && !retire)
      outstanding_next = outstanding + OW'(1);
    else if (!ar_hs && retire)
      outstanding_next = outstanding - OW'(1);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outstanding <= '0;
      beat_idx    <= '0;
      error_code  <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (clear) begin
        beat_idx   <= '0;
        error_code <= '0;
      end else if (r_hs) begin
        beat_idx <= r_last ? '0 : beat_idx + BURST_LEN_WIDTH'(1);
        if (r_id != id)
          error_code[ERR_ID_BIT] <= 1'b1;
        if (r_last != (beat_idx == len))
          error_code[ERR_LAST_BIT] <= 1'b1;
        if (!have_outstanding)
          error_code[ERR_ORPHAN_BIT] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_stride_rd_master.sv
// Strided AXI read initiator: issues cfg_numReqs bursts at
// cfg_baseAddr + k*cfg_stride, consumes and checks the returned beats.
// Ports:
//   clk, resetN              clock, async active-low reset
//   start, cfg_*             run request and its configuration
//   m_ar_*                   registered AR channel
//   m_r_*                    R channel (ready high whenever out of reset)
//   busy, done               run status
//   reqCnt, beatCnt          AR / R handshakes this run
//   errorCode                sticky {orphan, last, id} flags
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | issuing AR requests
// DRAIN | all AR issued, waiting for outstanding bursts to finish
// DONE  | run complete, waiting for start
module axi_stride_rd_master
  import prefetcher_tb_pkg::*;
#(
  parameter int ADDR_BITS            = 16,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int LOG_MAX_OUTSTANDING  = 2,
  parameter int REQ_CNT_WIDTH        = 16
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               start,
  input  logic [ADDR_BITS-1:0]               cfg_baseAddr,
  input  logic [ADDR_BITS-1:0]               cfg_stride,
  input  logic [BURST_LEN_WIDTH-1:0]         cfg_len,
  input  logic [TID_WIDTH-1:0]               cfg_id,
  input  logic [REQ_CNT_WIDTH-1:0]           cfg_numReqs,
  output logic                               m_ar_valid,
  input  logic                               m_ar_ready,
  output logic [ADDR_BITS-1:0]               m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]         m_ar_len,
  output logic [TID_WIDTH-1:0]               m_ar_id,
  input  logic                               m_r_valid,
  output logic                               m_r_ready,
  input  logic                               m_r_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0] m_r_data,
  input  logic [TID_WIDTH-1:0]               m_r_id,
  output logic                               busy,
  output logic                               done,
  output logic [REQ_CNT_WIDTH-1:0]           reqCnt,
  output logic [REQ_CNT_WIDTH-1:0]           beatCnt,
  output logic [2:0]                         errorCode
);

  localparam int            OW    = LOG_MAX_OUTSTANDING + 1;
  localparam logic [OW-1:0] LIMIT = OW'(1 << LOG_MAX_OUTSTANDING);

  run_state_t               state;
  logic [ADDR_BITS-1:0]     stride_q;
  logic [ADDR_BITS-1:0]     next_addr;
  logic [ADDR_BITS-1:0]     addr_nxt;
  logic [REQ_CNT_WIDTH-1:0] remaining;
  logic [REQ_CNT_WIDTH-1:0] rem_nxt;
  logic [OW-1:0]            outstanding;
  logic [OW-1:0]            outstanding_next;
  logic                     ar_hs;
  logic                     r_hs;
  logic                     start_ok;
  logic                     unused_data;

  assign ar_hs       = m_ar_valid && m_ar_ready;
  assign r_hs        = m_r_valid && m_r_ready;
  assign start_ok    = start && (state == IDLE || state == DONE);
  assign addr_nxt    = ar_hs ? next_addr + stride_q : next_addr;
  assign rem_nxt     = remaining - REQ_CNT_WIDTH'(ar_hs);
  assign unused_data = ^m_r_data;

  // m_ar_len / m_ar_id double as the latched run length and ID.
  axi_rd_beat_checker #(
    .BURST_LEN_WIDTH     (BURST_LEN_WIDTH),
    .TID_WIDTH           (TID_WIDTH),
    .LOG_MAX_OUTSTANDING (LOG_MAX_OUTSTANDING)
  ) u_checker (
    .clk              (clk),
    .resetN           (resetN),
    .clear            (start_ok),
    .ar_hs            (ar_hs),
    .r_hs             (r_hs),
    .r_last           (m_r_last),
    .r_id             (m_r_id),
    .id               (m_ar_id),
    .len              (m_ar_len),
    .outstanding      (outstanding),
    .outstanding_next (outstanding_next),
    .error_code       (errorCode)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      stride_q   <= '0;
      next_addr  <= '0;
      remaining  <= '0;
      m_ar_valid <= 1'b0;
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      m_r_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reqCnt     <= '0;
      beatCnt    <= '0;
    end else begin
      m_r_ready <= 1'b1;
      if (ar_hs) reqCnt  <= reqCnt + REQ_CNT_WIDTH'(1);
      if (r_hs)  beatCnt <= beatCnt + REQ_CNT_WIDTH'(1);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            done      <= 1'b0;
            stride_q  <= cfg_stride;
            next_addr <= cfg_baseAddr;
            remaining <= cfg_numReqs;
            m_ar_len  <= cfg_len;
            m_ar_id   <= cfg_id;
            reqCnt    <= '0;
            beatCnt   <= '0;
          end
        end
        RUN: begin
          if (ar_hs) begin
            next_addr <= addr_nxt;
            remaining <= rem_nxt;
          end
          // Only reload the slice when it is empty or being emptied,
          // so a stalled request stays stable.
          if (!m_ar_valid || m_ar_ready) begin
            m_ar_valid <= (rem_nxt != '0) && (outstanding_next < LIMIT);
            m_ar_addr  <= addr_nxt;
          end
          if (rem_nxt == '0)
            state <= DRAIN;
        end
        DRAIN: begin
          if (outstanding == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stride_rd_master.sv
module tb_axi_stride_rd_master;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_baseAddr = '0;
  logic [15:0] cfg_stride = '0;
  logic [7:0]  cfg_len = '0;
  logic [7:0]  cfg_id = '0;
  logic [15:0] cfg_numReqs = '0;
  logic        m_ar_valid;
  logic        m_ar_ready = 1'b0;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [7:0]  m_ar_id;
  logic        m_r_valid = 1'b0;
  logic        m_r_ready;
  logic        m_r_last = 1'b0;
  logic [7:0]  m_r_data = '0;
  logic [7:0]  m_r_id = '0;
  logic        busy;
  logic        done;
  logic [15:0] reqCnt;
  logic [15:0] beatCnt;
  logic [2:0]  errorCode;

  axi_stride_rd_master dut (
    .clk(clk), .resetN(resetN), .start(start),
    .cfg_baseAddr(cfg_baseAddr), .cfg_stride(cfg_stride), .cfg_len(cfg_len),
    .cfg_id(cfg_id), .cfg_numReqs(cfg_numReqs),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .busy(busy), .done(done), .reqCnt(reqCnt), .beatCnt(beatCnt),
    .errorCode(errorCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] id;
    logic       last;
  } beat_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [15:0] num;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    logic [15:0] exp_req;
    logic [15:0] exp_beat;
    logic [2:0]  exp_err;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // slave / reference model state
  beat_t       beat_q[$];
  int          ar_mode = 0;      // 0 always ready, 1 random, 2 held low
  bit          slave_en = 1'b1;
  bit          r_rand = 1'b0;
  bit          manual_r = 1'b0;
  int          model_out = 0;
  int          model_k = 0;
  logic [15:0] cur_base, cur_stride;
  logic [7:0]  cur_len, cur_id;
  logic [15:0] obs_first, obs_last;
  bit          prev_wait = 1'b0;
  logic [32:0] prev_ar;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs for the coming posedge, account the handshakes
  // that posedge will perform, then wait for the following negedge.
  task automatic step();
    if (prev_wait)
      check("ar_hold", {m_ar_valid, m_ar_addr, m_ar_len, m_ar_id}, prev_ar);
    case (ar_mode)
      0:       m_ar_ready = 1'b1;
      1:       m_ar_ready = 1'($urandom_range(0, 1));
      default: m_ar_ready = 1'b0;
    endcase
    if (!manual_r) begin
      if (slave_en && beat_q.size() > 0 && (!r_rand || $urandom_range(0, 3) != 0)) begin
        m_r_valid = 1'b1;
        m_r_id    = beat_q[0].id;
        m_r_last  = beat_q[0].last;
        m_r_data  = 8'($urandom);
      end else begin
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
      end
    end
    if (m_ar_valid)
      check("ar_limit", 64'(model_out < LIMIT), 64'd1);
    if (m_r_valid && m_r_ready) begin
      if (!manual_r && beat_q.size() > 0) void'(beat_q.pop_front());
      if (m_r_last && model_out > 0) model_out--;
    end
    if (m_ar_valid && m_ar_ready) begin
      logic [15:0] exp_addr;
      exp_addr = 16'(cur_base + 16'(model_k) * cur_stride);
      check("ar_addr", m_ar_addr, exp_addr);
      check("ar_len_id", {m_ar_len, m_ar_id}, {cur_len, cur_id});
      if (model_k == 0) obs_first = m_ar_addr;
      obs_last = m_ar_addr;
      for (int b = 0; b <= int'(cur_len); b++) begin
        beat_t bt;
        bt.id   = cur_id;
        bt.last = (b == int'(cur_len));
        beat_q.push_back(bt);
      end
      model_k++;
      model_out++;
    end
    prev_wait = m_ar_valid && !m_ar_ready;
    prev_ar   = {m_ar_valid, m_ar_addr, m_ar_len, m_ar_id};
    @(negedge clk);
  endtask

  task automatic begin_run(input logic [15:0] base, input logic [15:0] stride,
                           input logic [7:0] len, input logic [7:0] id,
                           input logic [15:0] num);
    cur_base = base; cur_stride = stride; cur_len = len; cur_id = id;
    model_k = 0; obs_first = '0; obs_last = '0;
    cfg_baseAddr = base; cfg_stride = stride; cfg_len = len;
    cfg_id = id; cfg_numReqs = num;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    check("done_reached", {done, busy}, 2'b10);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ar"}, {m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready}, 64'd0);
    check({tag, "_stat"}, {busy, done, reqCnt, beatCnt, errorCode}, 64'd0);
  endtask

  task automatic manual_beat(input logic [7:0] id, input logic last);
    manual_r  = 1'b1;
    m_r_valid = 1'b1; m_r_id = id; m_r_last = last;
    step();
    m_r_valid = 1'b0; m_r_last = 1'b0;
    beat_q.delete();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{16'h0eef, 16'h0003, 8'd0, 8'h05, 16'd4, 16'h0eef, 16'h0ef8, 16'd4, 16'd4,  3'b000};
    vecs[1] = '{16'hfffe, 16'h0002, 8'd0, 8'h01, 16'd3, 16'hfffe, 16'h0002, 16'd3, 16'd3,  3'b000};
    vecs[2] = '{16'h1000, 16'h0010, 8'd2, 8'haa, 16'd6, 16'h1000, 16'h1050, 16'd6, 16'd18, 3'b000};
    vecs[3] = '{16'h1234, 16'h0001, 8'd0, 8'h07, 16'd0, 16'h0000, 16'h0000, 16'd0, 16'd0,  3'b000};
    vecs[4] = '{16'h8000, 16'h8000, 8'd1, 8'h03, 16'd5, 16'h8000, 16'h8000, 16'd5, 16'd10, 3'b000};

    // reset values
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    resetN = 1'b1;
    step();
    check("r_ready_after_reset", m_r_ready, 1'b1);

    // unsolicited beat in IDLE
    manual_beat(8'h00, 1'b1);
    manual_r = 1'b0;
    step();
    check("idle_orphan", {errorCode, beatCnt, busy, done}, {3'b100, 16'd1, 2'b00});

    // directed table
    for (int v = 0; v < 5; v++) begin
      ar_mode = 0; slave_en = 1'b1; r_rand = 1'b0;
      begin_run(vecs[v].base, vecs[v].stride, vecs[v].len, vecs[v].id, vecs[v].num);
      wait_done(500);
      check($sformatf("vec%0d_addr", v), {obs_first, obs_last}, {vecs[v].exp_first, vecs[v].exp_last});
      check($sformatf("vec%0d_cnt", v), {reqCnt, beatCnt, errorCode},
            {vecs[v].exp_req, vecs[v].exp_beat, vecs[v].exp_err});
    end

    // R held off: limit of 4 outstanding bursts
    slave_en = 1'b0;
    begin_run(16'h0200, 16'h0040, 8'd3, 8'h05, 16'd5);
    repeat (30) step();
    check("holdoff_stall", {reqCnt, m_ar_valid, busy}, {16'd4, 2'b01});
    slave_en = 1'b1;
    wait_done(500);
    check("holdoff_final", {reqCnt, beatCnt, errorCode}, {16'd5, 16'd20, 3'b000});

    // AR ready held low for 5 cycles
    ar_mode = 2;
    begin_run(16'h0100, 16'h0004, 8'd2, 8'h09, 16'd2);
    for (int i = 0; i < 10 && !m_ar_valid; i++) step();
    check("stall_valid", m_ar_valid, 1'b1);
    repeat (5) step();
    check("stall_state", {m_ar_valid, m_ar_addr, reqCnt}, {1'b1, 16'h0100, 16'd0});
    ar_mode = 0;
    wait_done(500);
    check("stall_final", {reqCnt, beatCnt, errorCode}, {16'd2, 16'd6, 3'b000});

    // ID mismatch
    manual_r = 1'b1;
    begin_run(16'h0300, 16'h0001, 8'd0, 8'h05, 16'd1);
    for (int i = 0; i < 10 && model_k < 1; i++) step();
    manual_beat(8'h06, 1'b1);
    wait_done(50);
    check("id_err", errorCode, 3'b001);

    // early last on beat 0 of a 2-beat burst
    begin_run(16'h0400, 16'h0001, 8'd1, 8'h05, 16'd1);
    for (int i = 0; i < 10 && model_k < 1; i++) step();
    manual_beat(8'h05, 1'b1);
    wait_done(50);
    check("last_err", errorCode, 3'b010);
    manual_r = 1'b0;

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [15:0] b, s, n;
      logic [7:0]  l, id;
      b = 16'($urandom); s = 16'($urandom); l = 8'($urandom_range(0, 3));
      id = 8'($urandom); n = 16'($urandom_range(0, 12));
      ar_mode = 1; slave_en = 1'b1; r_rand = 1'b1;
      begin_run(b, s, l, id, n);
      wait_done(2000);
      check($sformatf("rand%0d_cnt", r), {reqCnt, beatCnt, errorCode},
            {n, 16'(int'(n) * (int'(l) + 1)), 3'b000});
      if (n != 0)
        check($sformatf("rand%0d_last", r), obs_last, 16'(b + (n - 16'd1) * s));
    end

    // reset in the middle of a run with two bursts outstanding
    ar_mode = 0; slave_en = 1'b0; r_rand = 1'b0;
    begin_run(16'h0500, 16'h0010, 8'd3, 8'h05, 16'd6);
    for (int i = 0; i < 10 && model_k < 2; i++) step();
    check("midrun_req", reqCnt, 16'd2);
    #2 resetN = 1'b0;
    #1;
    check_reset_state("async_reset");
    beat_q.delete(); model_out = 0; prev_wait = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    slave_en = 1'b1;
    step();
    begin_run(vecs[0].base, vecs[0].stride, vecs[0].len, vecs[0].id, vecs[0].num);
    wait_done(500);
    check("post_reset_run", {obs_first, obs_last, reqCnt, beatCnt, errorCode},
          {vecs[0].exp_first, vecs[0].exp_last, vecs[0].exp_req, vecs[0].exp_beat, vecs[0].exp_err});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_stride_rd_master.md
Name: axi_stride_rd_master

Overview:
- Synthesizable AXI read-address/read-data initiator.
- Drives the prefetcher's slave read port (s_ar_*/s_r_*) with a configurable strided request stream, consumes the returned beats and checks them on the fly.
- Replaces hand-written TRANSACTION stimulus in prefetcher benches; also usable as an on-chip traffic generator.
- Single in-order ID per run; bounded number of outstanding bursts.

Parameters:
- ADDR_BITS, 16, address width
- BURST_LEN_WIDTH, 8, AXI len width
- TID_WIDTH, 8, transaction ID width
- LOG_BLOCK_DATA_BYTES, 0, log2 of data bytes per beat; data width = 8<<LOG_BLOCK_DATA_BYTES
- LOG_MAX_OUTSTANDING, 2, outstanding AR limit = 1<<LOG_MAX_OUTSTANDING
- REQ_CNT_WIDTH, 16, width of request/beat counters

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; latches cfg_* and begins a run
- cfg_baseAddr  in  ADDR_BITS  first request address
- cfg_stride  in  ADDR_BITS  address increment per request, modulo 2^ADDR_BITS
- cfg_len  in  BURST_LEN_WIDTH  AXI len of every request (beats = len+1)
- cfg_id  in  TID_WIDTH  ID of every request
- cfg_numReqs  in  REQ_CNT_WIDTH  requests per run
- m_ar_valid  out  1  AR valid
- m_ar_ready  in  1  AR ready
- m_ar_addr  out  ADDR_BITS  AR address
- m_ar_len  out  BURST_LEN_WIDTH  AR len
- m_ar_id  out  TID_WIDTH  AR ID
- m_r_valid  in  1  R valid
- m_r_ready  out  1  R ready
- m_r_last  in  1  R last
- m_r_data  in  8<<LOG_BLOCK_DATA_BYTES  R data (not checked)
- m_r_id  in  TID_WIDTH  R ID
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- reqCnt  out  REQ_CNT_WIDTH  AR handshakes this run
- beatCnt  out  REQ_CNT_WIDTH  R handshakes this run
- errorCode  out  3  sticky flags: [0] ID mismatch, [1] LAST mismatch, [2] beat with nothing outstanding

Behaviour:
- Reset (asynchronous): state IDLE; m_ar_valid=0; m_ar_addr/len/id=0; m_r_ready=0; busy=0; done=0; counters=0; errorCode=0.
  - Reset mid-run aborts immediately; no partial completion.
- States and transitions:
  - IDLE, on start -> RUN.
  - RUN, when remaining==0 after the last AR handshake -> DRAIN.
  - DRAIN, when outstanding==0 -> DONE.
  - DONE, on start -> RUN.
  - start in RUN/DRAIN is ignored.
- On accepted start: latch cfg_*; clear reqCnt, beatCnt, errorCode; nextAddr=cfg_baseAddr; remaining=cfg_numReqs.
  - cfg_numReqs==0 goes RUN -> DRAIN -> DONE with no AR issued.
- AR channel (registered):
  - m_ar_valid rises no earlier than the cycle after start.
  - m_ar_valid asserts only when remaining>0 and outstanding < limit.
  - Once asserted, valid and addr/len/id stay stable until m_ar_ready.
  - On handshake: nextAddr += stride (wraps mod 2^ADDR_BITS); remaining--; reqCnt++.
  - Back-to-back AR: valid stays high next cycle if remaining>0 after the handshake and outstanding_next < limit.
- R channel:
  - m_r_ready=1 in every state except reset; beats arriving in IDLE/DONE are consumed and flagged.
  - Per handshake: beatCnt++; beatIdx tracks the position in the current burst.
  - m_r_id != latched id -> set errorCode[0].
  - m_r_last must equal (beatIdx==len); mismatch -> set errorCode[1].
  - beatIdx resets to 0 on a last beat and on an early last.
  - Beat with outstanding==0 -> set errorCode[2]; outstanding is not decremented.
- Outstanding counter (LOG_MAX_OUTSTANDING+1 bits):
  - +1 on AR handshake; -1 on R handshake with m_r_last.
  - Both in the same cycle -> unchanged.
  - Never exceeds limit; never underflows.
- errorCode flags are sticky until the next accepted start. Flags do not stop the run.

Decomposition:
- Shared package prefetcher_tb_pkg holds the state enum {IDLE,RUN,DRAIN,DONE} and the errorCode bit-index constants.
- One sub-module, axi_rd_beat_checker, covers beatIdx, outstanding counter and error flags; it takes handshake strobes plus len/id.
- The top holds the FSM, address generation and the AR register slice.

Test Plan:
- base=0x0eef, stride=3, len=0, id=5, numReqs=4, slave always ready -> AR addrs 0x0eef, 0x0ef2, 0x0ef5, 0x0ef8; done after 4 beats; errorCode=0.
- base=0xfffe, stride=2, numReqs=3 -> addrs 0xfffe, 0x0000, 0x0002 (wrap).
- len=3, limit=4, R held off -> exactly 4 AR issued, m_ar_valid low until the first R last; then the 5th AR issues.
- m_ar_ready low for 5 cycles -> addr/len/id stable throughout; reqCnt unchanged until the handshake.
- R beat with id=6 while cfg_id=5 -> errorCode[0]=1. len=1 with last on beat 0 -> errorCode[1]=1. Unsolicited beat in IDLE -> errorCode[2]=1.
- resetN low during RUN with 2 outstanding -> all outputs at reset values asynchronously; a new start after reset runs a clean sequence.
